float_sq_mul_gen: RTL and testbench
===================================

FLOAT_SQ_MUL_GEN -- requirements
Module: float_sq_mul_gen

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent field width, legal range 4..11.
REQ-002 SHALL have parameter MAN_W, default 23: mantissa field width, legal range 3..52; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: request; sampled only in IDLE.
REQ-006 SHALL have port float_in_sq, input, W: operand a, IEEE-style {sign, exp, man}, squared.
REQ-007 SHALL have port float_in_mul, input, W: operand b, multiplier.
REQ-008 SHALL have port float_out, output, W: result fl(fl(a*a)*b).
REQ-009 SHALL have port ready, output, 1: one-cycle pulse marking float_out valid.
REQ-010 SHALL have port busy, output, 1: high from the cycle after start is accepted until the cycle after the ready pulse.

Function
REQ-011 SHALL use FSM states IDLE -> SQ -> RND1 -> MUL -> RND2 -> IDLE, one state per cycle.
REQ-012 SHALL capture float_in_sq and float_in_mul on the rising edge at which start=1 in IDLE; later input changes have no effect on the operation in flight.
REQ-013 SHALL assert ready during RND2 only, i.e. exactly 4 cycles after the accepting edge, for exactly one cycle.
REQ-014 SHALL update float_out on the same edge ready rises and hold it until the next result or reset.
REQ-015 SHALL ignore start while busy; start held high continuously SHALL begin a new operation on the first edge back in IDLE.
REQ-016 SHALL round each product (a*a, then result*b) to nearest, ties-to-even, at MAN_W fraction bits.
REQ-017 SHALL compute the sign as sign(b); the square is always non-negative.
REQ-018 SHALL treat inputs with exponent field 0 (zero or denormal) as signed zero, and flush any result below the minimum normal to zero with sign(b).
REQ-019 SHALL compute the biased exponent in EXP_W+2 bits signed so that overflow and underflow of the intermediate square are detected without wrap.

Reset
REQ-020 SHALL, while rst=1, force state IDLE, float_out=0, ready=0, busy=0 and clear the captured operands.
REQ-021 SHALL abort any operation in flight on rst with no ready pulse; first start is accepted on the first rising edge with rst=0.

Configuration
REQ-022 SHALL honour macro FLOAT_SQ_MUL_SPECIAL_EN.
REQ-023 With FLOAT_SQ_MUL_SPECIAL_EN defined, the block SHALL return canonical quiet NaN (exp all ones, mantissa MSB only, sign 0) for any NaN input or for inf*0; inf otherwise propagates; overflow yields signed inf.
REQ-024 Without FLOAT_SQ_MUL_SPECIAL_EN, the block SHALL treat exponent-all-ones inputs as the largest finite magnitude of the same sign and saturate overflow to the largest finite magnitude; no NaN or inf is ever produced.

Structure
REQ-025 SHALL place the FSM state enum, the exponent-bias function and the field-extraction helper functions in shared package float_pkg.
REQ-026 SHALL instantiate one sub-module float_mul_rne (registered single multiply with normalise and RNE) and reuse it for both products.

Verification
REQ-027 SHALL cover: defaults, a=0x40000000 (2.0), b=0x40400000 (3.0), start pulse -> ready exactly 4 cycles later, float_out=0x41400000.
REQ-028 SHALL cover: a=0x3FC00000, b=0xC0000000 -> 0xC0900000 (-4.5); a=0x80000000, b=0x40400000 -> 0x00000000.
REQ-029 SHALL cover: a=0x7149F2CA (1e30), b=0x3F800000 -> 0x7F800000 with FLOAT_SQ_MUL_SPECIAL_EN, 0x7F7FFFFF without; a=0x7FC00001 -> 0x7FC00000 with macro.
REQ-030 SHALL cover: start re-pulsed during SQ/MUL -> ignored, single ready, result of first operands; rst asserted in MUL -> no ready, float_out=0, next start completes normally.
REQ-031 SHALL cover: EXP_W=5, MAN_W=10, a=0x4000, b=0x4200 -> float_out=0x4A00 after 4 cycles.
REQ-032 SHALL cover: start held high for 12 cycles -> ready pulses every 5 cycles, busy low only in IDLE cycles.

Source files
------------

// File: rtl/float_pkg.sv
// Shared FSM encoding, exponent bias and IEEE-style field extraction for float_sq_mul_gen.
package float_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    RND1 = 3'd2,
    MUL  = 3'd3,
    RND2 = 3'd4
  } fsm_state_e;

  localparam int MAX_W = 64;

  function automatic int exp_bias(input int exp_w);
    return (32'sd1 <<< (exp_w - 1)) - 32'sd1;
  endfunction

  function automatic logic get_sign(input logic [MAX_W-1:0] f, input int w);
    logic [MAX_W-1:0] t;
    t = f >> (w - 1);
    return 1'(t);
  endfunction

  function automatic logic [10:0] get_exp(input logic [MAX_W-1:0] f, input int man_w,
                                          input int exp_w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] t;
    mask = (64'd1 << exp_w) - 64'd1;
    t    = (f >> man_w) & mask;
    return 11'(t);
  endfunction

  function automatic logic [51:0] get_man(input logic [MAX_W-1:0] f, input int man_w);
    logic [MAX_W-1:0] mask;
    mask = (64'd1 << man_w) - 64'd1;
    return 52'(f & mask);
  endfunction

endpackage

// File: rtl/float_mul_rne.sv
// One floating-point multiply with normalise and round-to-nearest-even, result registered.
// FLOAT_SQ_MUL_SPECIAL_EN selects NaN/inf handling; otherwise everything saturates to max finite.
module float_mul_rne #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] op_x,
  input  logic [W-1:0] op_y,
  output logic [W-1:0] res
);
  import float_pkg::*;

  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = exp_bias(EXP_W);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [MAN_W-1:0] MAN_ONES = {MAN_W{1'b1}};
  localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};
  localparam logic [EW2-1:0]   EXP_OVF  = {2'b00, EXP_ONES};

  logic                  sign_s;
  logic [EXP_W-1:0]      ex_raw_s, ey_raw_s, ex_s, ey_s;
  logic [MAN_W-1:0]      mx_raw_s, my_raw_s, mx_s, my_s;
  logic                  x_zero_s, y_zero_s;
`ifdef FLOAT_SQ_MUL_SPECIAL_EN
  logic                  x_nan_s, y_nan_s, x_inf_s, y_inf_s;
`endif
  logic [PW-1:0]         prod_s;
  logic [PW-2:0]         norm_s;
  logic [MAN_W-1:0]      frac_s;
  logic                  round_up_s;
  logic [MAN_W:0]        frac_r_s;
  logic signed [EW2-1:0] exp_pre_s, exp_post_s;
  logic                  underflow_s, overflow_s;
  logic [W-1:0]          res_d, res_q;

  // Decode, multiply, normalise, round and classify the product.
  always_comb begin
    sign_s   = get_sign(64'(op_x), W) ^ get_sign(64'(op_y), W);
    ex_raw_s = EXP_W'(get_exp(64'(op_x), MAN_W, EXP_W));
    ey_raw_s = EXP_W'(get_exp(64'(op_y), MAN_W, EXP_W));
    mx_raw_s = MAN_W'(get_man(64'(op_x), MAN_W));
    my_raw_s = MAN_W'(get_man(64'(op_y), MAN_W));
    x_zero_s = (ex_raw_s == EXP_ZERO);
    y_zero_s = (ey_raw_s == EXP_ZERO);
`ifdef FLOAT_SQ_MUL_SPECIAL_EN
    x_nan_s  = (ex_raw_s == EXP_ONES) && (mx_raw_s != MAN_ZERO);
    y_nan_s  = (ey_raw_s == EXP_ONES) && (my_raw_s != MAN_ZERO);
    x_inf_s  = (ex_raw_s == EXP_ONES) && (mx_raw_s == MAN_ZERO);
    y_inf_s  = (ey_raw_s == EXP_ONES) && (my_raw_s == MAN_ZERO);
`endif
    // All-ones exponents become max finite; with specials on, the flags above override anyway.
    ex_s = (ex_raw_s == EXP_ONES) ? EXP_MAXF : ex_raw_s;
    ey_s = (ey_raw_s == EXP_ONES) ? EXP_MAXF : ey_raw_s;
    mx_s = (ex_raw_s == EXP_ONES) ? MAN_ONES : mx_raw_s;
    my_s = (ey_raw_s == EXP_ONES) ? MAN_ONES : my_raw_s;

    prod_s     = PW'({1'b1, mx_s}) * PW'({1'b1, my_s});
    norm_s     = prod_s[PW-1] ? prod_s[PW-2:0] : {prod_s[PW-3:0], 1'b0};
    frac_s     = norm_s[PW-2 -: MAN_W];
    round_up_s = norm_s[MAN_W] & ((|norm_s[MAN_W-1:0]) | frac_s[0]);
    frac_r_s   = {1'b0, frac_s} + {{MAN_W{1'b0}}, round_up_s};
    exp_pre_s  = $signed({2'b00, ex_s}) + $signed({2'b00, ey_s}) - $signed(EW2'(BIAS))
               + $signed({{(EW2-1){1'b0}}, prod_s[PW-1]});
    exp_post_s = exp_pre_s + $signed({{(EW2-1){1'b0}}, frac_r_s[MAN_W]});
    underflow_s = exp_pre_s[EW2-1] || (exp_pre_s == $signed({EW2{1'b0}}));
    overflow_s  = !exp_post_s[EW2-1] && (exp_post_s >= $signed(EXP_OVF));

    res_d = {sign_s, exp_post_s[EXP_W-1:0], frac_r_s[MAN_W-1:0]};
`ifdef FLOAT_SQ_MUL_SPECIAL_EN
    if (x_nan_s || y_nan_s || (x_inf_s && y_zero_s) || (y_inf_s && x_zero_s)) begin
      res_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (x_inf_s || y_inf_s) begin
      res_d = {sign_s, EXP_ONES, MAN_ZERO};
    end else if (x_zero_s || y_zero_s || underflow_s) begin
      res_d = {sign_s, EXP_ZERO, MAN_ZERO};
    end else if (overflow_s) begin
      res_d = {sign_s, EXP_ONES, MAN_ZERO};
    end else begin
      res_d = {sign_s, exp_post_s[EXP_W-1:0], frac_r_s[MAN_W-1:0]};
    end
`else
    if (x_zero_s || y_zero_s || underflow_s) begin
      res_d = {sign_s, EXP_ZERO, MAN_ZERO};
    end else if (overflow_s) begin
      res_d = {sign_s, EXP_MAXF, MAN_ONES};
    end else begin
      res_d = {sign_s, exp_post_s[EXP_W-1:0], frac_r_s[MAN_W-1:0]};
    end
`endif
  end

  // Result register, loaded only while the controller launches a product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= {W{1'b0}};
    end else if (en) begin
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: rtl/float_sq_mul_gen.sv
// float_sq_mul_gen: sequential fl(fl(a*a)*b) reusing one rounding multiplier for both products.
// Build option FLOAT_SQ_MUL_SPECIAL_EN selects IEEE NaN/inf handling instead of saturation.
module float_sq_mul_gen #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] float_in_sq,
  input  logic [W-1:0] float_in_mul,
  output logic [W-1:0] float_out,
  output logic         ready,
  output logic         busy
);
  import float_pkg::*;

  fsm_state_e   state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic         ready_q, ready_d, busy_q, busy_d;
  logic [W-1:0] op_x_s, op_y_s, mul_res_s;
  logic         mul_en_s;

  float_mul_rne #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .en  (mul_en_s),
    .op_x(op_x_s),
    .op_y(op_y_s),
    .res (mul_res_s)
  );

  // Next-state, operand steering and output staging.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    mul_en_s = 1'b0;
    op_x_s   = a_q;
    op_y_s   = a_q;
    // The multiplier rounds before its register, so RND1 already launches square*b.
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SQ;
          a_d     = float_in_sq;
          b_d     = float_in_mul;
        end else begin
          state_d = IDLE;
        end
      end
      SQ: begin
        state_d  = RND1;
        mul_en_s = 1'b1;
      end
      RND1: begin
        state_d  = MUL;
        mul_en_s = 1'b1;
        op_x_s   = mul_res_s;
        op_y_s   = b_q;
      end
      MUL: begin
        state_d = RND2;
        out_d   = mul_res_s;
      end
      RND2: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == RND2);
    busy_d  = (state_d != IDLE);
  end

  // State, captured operands and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      out_q   <= {W{1'b0}};
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign float_out = out_q;
  assign ready     = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_float_sq_mul_gen.sv
// Directed plus randomized bench for float_sq_mul_gen against a real-arithmetic reference model.
module tb_float_sq_mul_gen;

  logic        clk = 1'b0;
  logic        rst, start, ready, busy;
  logic [31:0] a, b, out;
  logic        start16, ready16, busy16;
  logic [15:0] a16, b16, out16;
  int          passed = 0, failed = 0, total = 0;

  always #5 clk = ~clk;

  float_sq_mul_gen dut (
    .clk(clk), .rst(rst), .start(start), .float_in_sq(a), .float_in_mul(b),
    .float_out(out), .ready(ready), .busy(busy)
  );

  float_sq_mul_gen #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .float_in_sq(a16), .float_in_mul(b16),
    .float_out(out16), .ready(ready16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic real mag(input logic [31:0] f);
    int e, m;
    e = int'(f[30:23]);
    m = int'(f[22:0]);
    if (e == 255) begin
      e = 254;
      m = 32'h007F_FFFF;
    end
    return (8388608.0 + m) * (2.0 ** (e - 150));
  endfunction

  // Single-precision product rounded to nearest even, from the exact real product.
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic        s, up;
    logic [63:0] d;
    logic [22:0] keep;
    logic [28:0] rest;
    logic [24:0] m;
    int          de;
    real         p;
    s = x[31] ^ y[31];
`ifdef FLOAT_SQ_MUL_SPECIAL_EN
    if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0) ||
        (x[30:23] == 8'hFF && y[30:23] == 8'h00) || (y[30:23] == 8'hFF && x[30:23] == 8'h00))
      return 32'h7FC0_0000;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return {s, 8'hFF, 23'd0};
`endif
    if (x[30:23] == 8'h00 || y[30:23] == 8'h00) return {s, 31'd0};
    p  = mag(x) * mag(y);
    d  = $realtobits(p);
    de = int'(d[62:52]) - 1023;
    if (de < -126) return {s, 31'd0};
    keep = d[51:29];
    rest = d[28:0];
    up   = (rest > 29'h1000_0000) || (rest == 29'h1000_0000 && keep[0]);
    m    = {2'b01, keep} + {24'd0, up};
    if (m[24]) de = de + 1;
    keep = m[22:0];
    if (de > 127) begin
`ifdef FLOAT_SQ_MUL_SPECIAL_EN
      return {s, 8'hFF, 23'd0};
`else
      return {s, 8'hFE, 23'h7F_FFFF};
`endif
    end
    return {s, 8'(de + 127), keep};
  endfunction

  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic [31:0] exp,
                        input string tag);
    a = ai;
    b = bi;
    start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_rdy_sq"}, 32'(ready), 32'd0);
    step();
    check({tag, "_rdy_rnd1"}, 32'(ready), 32'd0);
    step();
    check({tag, "_rdy_mul"}, 32'(ready), 32'd0);
    step();
    check({tag, "_rdy"}, 32'(ready), 32'd1);
    check({tag, "_out"}, out, exp);
    step();
    check({tag, "_rdy_end"}, 32'(ready), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, out, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    start16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
    step();
    a = $urandom;
    b = $urandom;
    step();
    check("rst_out", out, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    run_op(32'h4000_0000, 32'h4040_0000, 32'h4140_0000, "two_three");
    run_op(32'h3FC0_0000, 32'hC000_0000, 32'hC090_0000, "neg_4p5");
    run_op(32'h8000_0000, 32'h4040_0000, 32'h0000_0000, "neg_zero");
    run_op(32'h1F80_0000, 32'hC040_0000, 32'h8000_0000, "sq_underflow");
`ifdef FLOAT_SQ_MUL_SPECIAL_EN
    run_op(32'h7149_F2CA, 32'h3F80_0000, 32'h7F80_0000, "ovf_inf");
    run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
`else
    run_op(32'h7149_F2CA, 32'h3F80_0000, 32'h7F7F_FFFF, "ovf_sat");
    run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7F7F_FFFF, "allones_in");
`endif

    // Re-pulsed start during SQ and MUL must not disturb the first operation.
    a = 32'h3FC0_0000; b = 32'hC000_0000; start = 1'b1;
    step();
    a = 32'h4000_0000; b = 32'h4040_0000;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("repulse_rdy", 32'(ready), 32'd1);
    check("repulse_out", out, 32'hC090_0000);
    step();
    check("repulse_rdy_end", 32'(ready), 32'd0);
    step();
    check("repulse_no_restart", 32'(busy), 32'd0);

    // Reset in MUL aborts the operation; the next start runs normally.
    a = 32'h4000_0000; b = 32'h4040_0000; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #1 rst = 1'b1;
    #1;
    check("abort_out", out, 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    ra = 32'h3F80_0000 | 32'($urandom_range(0, 32'h7F_FFFF));
    rb = 32'h4000_0000 | 32'($urandom_range(0, 32'h7F_FFFF));
    run_op(ra, rb, fmul(fmul(ra, ra), rb), "after_abort");

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i < 8) begin
        ra[30:23] = 8'(96 + $urandom_range(0, 60));
        rb[30:23] = 8'(100 + $urandom_range(0, 50));
      end
      run_op(ra, rb, fmul(fmul(ra, ra), rb), $sformatf("rand%0d", i));
    end

    // Start held high: a new operation every five cycles, busy low only in IDLE.
    a = 32'h4000_0000; b = 32'h4040_0000; start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      check($sformatf("hold_rdy%0d", n), 32'(ready), 32'((n - 1) % 5 == 3));
      check($sformatf("hold_busy%0d", n), 32'(busy), 32'((n - 1) % 5 != 4));
      if ((n - 1) % 5 == 3) check($sformatf("hold_out%0d", n), out, 32'h4140_0000);
    end
    start = 1'b0;
    step();
    step();
    check("hold_last_rdy", 32'(ready), 32'd1);
    step();
    check("hold_idle", 32'(busy), 32'd0);

    // Half-precision instance: 2.0^2 * 3.0 = 12.0.
    a16 = 16'h4000; b16 = 16'h4200; start16 = 1'b1;
    step();
    start16 = 1'b0;
    step();
    step();
    check("h_rdy_early", 32'(ready16), 32'd0);
    step();
    check("h_rdy", 32'(ready16), 32'd1);
    check("h_out", 32'(out16), 32'h0000_4A00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
